// File: rtl/dest_reg_scoreboard.sv
// Destination-register scoreboard: carries write destinations through EX/MEM/WB,
// drives the register-file write port and raises RAW-hazard stalls.
// Optional macro SCOREBOARD_FWD_EN: forwarding present, stall only on load-use.
module dest_reg_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int REG_W    = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                id_valid,
  input  logic                id_regwrite,
  input  logic                id_memread,
  input  logic [REG_W-1:0]    id_dest,
  input  logic [REG_W-1:0]    id_rs,
  input  logic [REG_W-1:0]    id_rt,
  input  logic                id_uses_rs,
  input  logic                id_uses_rt,
  input  logic                ex_flush,
  output logic                hazard_stall,
  output logic                wb_we,
  output logic [REG_W-1:0]    wb_dest,
  output logic [NUM_REGS-1:0] pending_mask,
  output logic [REG_W-1:0]    ex_dest_o,
  output logic [REG_W-1:0]    mem_dest_o
);

  logic             ex_valid_q, ex_load_q, mem_valid_q, mem_load_q, wb_valid_q, wb_load_q;
  logic [REG_W-1:0] ex_dest_q, mem_dest_q, wb_dest_q;
  logic             ex_valid_d, ex_load_d, mem_valid_d;
  logic [REG_W-1:0] ex_dest_d;
  logic             cap;
  logic             need_rs, need_rt;
  logic             rs_ex, rt_ex, rs_mem, rt_mem;

  // A write to $0 is never tracked.
  assign cap = id_valid & id_regwrite & (id_dest != '0);

  assign need_rs = id_valid & id_uses_rs & (id_rs != '0);
  assign need_rt = id_valid & id_uses_rt & (id_rt != '0);

  assign rs_ex  = need_rs & ex_valid_q  & (ex_dest_q  == id_rs);
  assign rt_ex  = need_rt & ex_valid_q  & (ex_dest_q  == id_rt);
  assign rs_mem = need_rs & mem_valid_q & (mem_dest_q == id_rs);
  assign rt_mem = need_rt & mem_valid_q & (mem_dest_q == id_rt);

  // WB never stalls: the register file writes first half, reads second half.
`ifdef SCOREBOARD_FWD_EN
  logic unused_mem_load;
  assign unused_mem_load = rs_mem | rt_mem;
  assign hazard_stall = (rs_ex | rt_ex) & ex_load_q;
`else
  assign hazard_stall = rs_ex | rt_ex | rs_mem | rt_mem;
`endif

  always_comb begin
    ex_valid_d  = cap;
    ex_dest_d   = id_dest;
    ex_load_d   = id_memread;
    mem_valid_d = ex_valid_q & ~ex_flush;
    if (hazard_stall) begin
      ex_valid_d = 1'b0;
      ex_dest_d  = '0;
      ex_load_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid_q  <= 1'b0;
      ex_dest_q   <= '0;
      ex_load_q   <= 1'b0;
      mem_valid_q <= 1'b0;
      mem_dest_q  <= '0;
      mem_load_q  <= 1'b0;
      wb_valid_q  <= 1'b0;
      wb_dest_q   <= '0;
      wb_load_q   <= 1'b0;
    end else begin
      ex_valid_q  <= ex_valid_d;
      ex_dest_q   <= ex_dest_d;
      ex_load_q   <= ex_load_d;
      mem_valid_q <= mem_valid_d;
      mem_dest_q  <= ex_dest_q;
      mem_load_q  <= ex_load_q;
      wb_valid_q  <= mem_valid_q;
      wb_dest_q   <= mem_dest_q;
      wb_load_q   <= mem_load_q;
    end
  end

  always_comb begin
    pending_mask = '0;
    for (int k = 1; k < NUM_REGS; k++) begin
      pending_mask[k] = (ex_valid_q  & (ex_dest_q  == REG_W'(k))) |
                        (mem_valid_q & (mem_dest_q == REG_W'(k))) |
                        (wb_valid_q  & (wb_dest_q  == REG_W'(k)));
    end
  end

  logic unused_load;
  assign unused_load = mem_load_q ^ wb_load_q;

  assign wb_we      = wb_valid_q;
  assign wb_dest    = wb_dest_q;
  assign ex_dest_o  = ex_dest_q;
  assign mem_dest_o = mem_dest_q;

endmodule

// File: tb/tb_dest_reg_scoreboard.sv
// Directed bench for dest_reg_scoreboard; inputs change 1ns after the rising
// edge and outputs are compared 1ns later, well away from the clock edge.
module tb_dest_reg_scoreboard;

  logic        clk, reset;
  logic        id_valid, id_regwrite, id_memread, id_uses_rs, id_uses_rt, ex_flush;
  logic [4:0]  id_dest, id_rs, id_rt;
  logic        hazard_stall, wb_we;
  logic [4:0]  wb_dest, ex_dest_o, mem_dest_o;
  logic [31:0] pending_mask;

  int n_checks = 0;
  int n_fails  = 0;

  dest_reg_scoreboard #(.NUM_REGS(32), .REG_W(5)) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_regwrite(id_regwrite), .id_memread(id_memread),
    .id_dest(id_dest), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .ex_flush(ex_flush),
    .hazard_stall(hazard_stall), .wb_we(wb_we), .wb_dest(wb_dest),
    .pending_mask(pending_mask), .ex_dest_o(ex_dest_o), .mem_dest_o(mem_dest_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to the next edge, then to the drive point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive(input logic v, input logic rw, input logic mr, input logic [4:0] d,
                       input logic [4:0] rs, input logic urs, input logic [4:0] rt, input logic urt);
    id_valid = v; id_regwrite = rw; id_memread = mr; id_dest = d;
    id_rs = rs; id_uses_rs = urs; id_rt = rt; id_uses_rt = urt;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    ex_flush = 1'b0;
  endtask

  task automatic drain();
    idle();
    repeat (4) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; idle();
    tick(); tick();
    reset = 1'b0;
    settle();
    n_checks++; if (wb_we !== 1'b0) begin $display("FAIL reset_wb_we: got %b want 0", wb_we); n_fails++; end
    n_checks++; if (wb_dest !== 5'd0) begin $display("FAIL reset_wb_dest: got %0d want 0", wb_dest); n_fails++; end
    n_checks++; if (ex_dest_o !== 5'd0) begin $display("FAIL reset_ex_dest: got %0d want 0", ex_dest_o); n_fails++; end
    n_checks++; if (mem_dest_o !== 5'd0) begin $display("FAIL reset_mem_dest: got %0d want 0", mem_dest_o); n_fails++; end
    n_checks++; if (pending_mask !== 32'h0) begin $display("FAIL reset_pending: got %h want 0", pending_mask); n_fails++; end
    n_checks++; if (hazard_stall !== 1'b0) begin $display("FAIL reset_stall: got %b want 0", hazard_stall); n_fails++; end
  endtask

  task automatic test_latency();
    drive(1'b1, 1'b1, 1'b0, 5'd5, 5'd0, 1'b0, 5'd0, 1'b0);
    tick(); idle(); settle();
    n_checks++; if (ex_dest_o !== 5'd5) begin $display("FAIL lat_ex_dest: got %0d want 5", ex_dest_o); n_fails++; end
    n_checks++; if (pending_mask !== 32'h20) begin $display("FAIL lat_pend_c1: got %h want 20", pending_mask); n_fails++; end
    n_checks++; if (wb_we !== 1'b0) begin $display("FAIL lat_we_c1: got %b want 0", wb_we); n_fails++; end
    tick(); settle();
    n_checks++; if (mem_dest_o !== 5'd5) begin $display("FAIL lat_mem_dest: got %0d want 5", mem_dest_o); n_fails++; end
    n_checks++; if (pending_mask !== 32'h20) begin $display("FAIL lat_pend_c2: got %h want 20", pending_mask); n_fails++; end
    n_checks++; if (wb_we !== 1'b0) begin $display("FAIL lat_we_c2: got %b want 0", wb_we); n_fails++; end
    tick(); settle();
    n_checks++; if (wb_we !== 1'b1) begin $display("FAIL lat_we_c3: got %b want 1", wb_we); n_fails++; end
    n_checks++; if (wb_dest !== 5'd5) begin $display("FAIL lat_wb_dest: got %0d want 5", wb_dest); n_fails++; end
    n_checks++; if (pending_mask !== 32'h20) begin $display("FAIL lat_pend_c3: got %h want 20", pending_mask); n_fails++; end
    tick(); settle();
    n_checks++; if (wb_we !== 1'b0) begin $display("FAIL lat_we_c4: got %b want 0", wb_we); n_fails++; end
    n_checks++; if (pending_mask !== 32'h0) begin $display("FAIL lat_pend_c4: got %h want 0", pending_mask); n_fails++; end
    drain();
  endtask

  task automatic test_jal_and_zero();
    drive(1'b1, 1'b1, 1'b0, 5'd31, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    drive(1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    settle();
    n_checks++; if (pending_mask !== 32'h8000_0000) begin $display("FAIL jal_pend_c1: got %h want 80000000", pending_mask); n_fails++; end
    tick(); idle(); settle();
    n_checks++; if (pending_mask !== 32'h8000_0000) begin $display("FAIL zero_pend_c2: got %h want 80000000", pending_mask); n_fails++; end
    tick(); settle();
    n_checks++; if (wb_we !== 1'b1) begin $display("FAIL jal_we: got %b want 1", wb_we); n_fails++; end
    n_checks++; if (wb_dest !== 5'd31) begin $display("FAIL jal_wb_dest: got %0d want 31", wb_dest); n_fails++; end
    tick(); settle();
    n_checks++; if (wb_we !== 1'b0) begin $display("FAIL zero_we: got %b want 0", wb_we); n_fails++; end
    n_checks++; if (pending_mask !== 32'h0) begin $display("FAIL zero_pend_c4: got %h want 0", pending_mask); n_fails++; end
    drain();
  endtask

`ifndef SCOREBOARD_FWD_EN
  task automatic test_back_to_back();
    drive(1'b1, 1'b1, 1'b0, 5'd8, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    drive(1'b1, 1'b1, 1'b0, 5'd10, 5'd8, 1'b1, 5'd0, 1'b0);
    settle();
    n_checks++; if (hazard_stall !== 1'b1) begin $display("FAIL b2b_stall_c1: got %b want 1", hazard_stall); n_fails++; end
    tick(); settle();
    n_checks++; if (hazard_stall !== 1'b1) begin $display("FAIL b2b_stall_c2: got %b want 1", hazard_stall); n_fails++; end
    n_checks++; if (ex_dest_o !== 5'd0) begin $display("FAIL b2b_bubble_ex: got %0d want 0", ex_dest_o); n_fails++; end
    tick(); settle();
    n_checks++; if (hazard_stall !== 1'b0) begin $display("FAIL b2b_stall_c3: got %b want 0", hazard_stall); n_fails++; end
    n_checks++; if (wb_we !== 1'b1 || wb_dest !== 5'd8) begin $display("FAIL b2b_wb_c3: got we=%b dest=%0d want we=1 dest=8", wb_we, wb_dest); n_fails++; end
    tick(); idle(); settle();
    n_checks++; if (ex_dest_o !== 5'd10) begin $display("FAIL b2b_dep_ex: got %0d want 10", ex_dest_o); n_fails++; end
    n_checks++; if (wb_we !== 1'b0) begin $display("FAIL b2b_bubble1: got %b want 0", wb_we); n_fails++; end
    tick(); settle();
    n_checks++; if (wb_we !== 1'b0) begin $display("FAIL b2b_bubble2: got %b want 0", wb_we); n_fails++; end
    tick(); settle();
    n_checks++; if (wb_we !== 1'b1 || wb_dest !== 5'd10) begin $display("FAIL b2b_dep_wb: got we=%b dest=%0d want we=1 dest=10", wb_we, wb_dest); n_fails++; end
    drain();
  endtask

  task automatic test_distance_two();
    drive(1'b1, 1'b1, 1'b0, 5'd3, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    drive(1'b1, 1'b1, 1'b0, 5'd4, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    drive(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd3, 1'b1);
    settle();
    n_checks++; if (hazard_stall !== 1'b1) begin $display("FAIL d2_stall_c2: got %b want 1", hazard_stall); n_fails++; end
    tick(); settle();
    n_checks++; if (hazard_stall !== 1'b0) begin $display("FAIL d2_stall_c3: got %b want 0", hazard_stall); n_fails++; end
    drain();
  endtask
`else
  task automatic test_fwd();
    drive(1'b1, 1'b1, 1'b1, 5'd9, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    drive(1'b1, 1'b1, 1'b0, 5'd11, 5'd9, 1'b1, 5'd0, 1'b0);
    settle();
    n_checks++; if (hazard_stall !== 1'b1) begin $display("FAIL fwd_load_stall_c1: got %b want 1", hazard_stall); n_fails++; end
    tick(); settle();
    n_checks++; if (hazard_stall !== 1'b0) begin $display("FAIL fwd_load_stall_c2: got %b want 0", hazard_stall); n_fails++; end
    drain();
    drive(1'b1, 1'b1, 1'b0, 5'd9, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    drive(1'b1, 1'b1, 1'b0, 5'd11, 5'd0, 1'b0, 5'd9, 1'b1);
    settle();
    n_checks++; if (hazard_stall !== 1'b0) begin $display("FAIL fwd_alu_stall: got %b want 0", hazard_stall); n_fails++; end
    drain();
  endtask
`endif

  task automatic test_flush();
    drive(1'b1, 1'b1, 1'b0, 5'd12, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    drive(1'b1, 1'b0, 1'b0, 5'd0, 5'd12, 1'b1, 5'd0, 1'b0);
    ex_flush = 1'b1;
    settle();
    n_checks++; if (pending_mask !== 32'h1000) begin $display("FAIL flush_pend_c1: got %h want 1000", pending_mask); n_fails++; end
`ifndef SCOREBOARD_FWD_EN
    n_checks++; if (hazard_stall !== 1'b1) begin $display("FAIL flush_stall_c1: got %b want 1", hazard_stall); n_fails++; end
`endif
    tick();
    ex_flush = 1'b0;
    settle();
    n_checks++; if (pending_mask !== 32'h0) begin $display("FAIL flush_pend_c2: got %h want 0", pending_mask); n_fails++; end
    n_checks++; if (hazard_stall !== 1'b0) begin $display("FAIL flush_stall_c2: got %b want 0", hazard_stall); n_fails++; end
    idle();
    tick(); settle();
    n_checks++; if (wb_we !== 1'b0) begin $display("FAIL flush_we_c3: got %b want 0", wb_we); n_fails++; end
    tick(); settle();
    n_checks++; if (wb_we !== 1'b0) begin $display("FAIL flush_we_c4: got %b want 0", wb_we); n_fails++; end
    drain();
  endtask

  task automatic test_reset_mid_stall();
    drive(1'b1, 1'b1, 1'b1, 5'd7, 5'd0, 1'b0, 5'd0, 1'b0);
    tick();
    drive(1'b1, 1'b1, 1'b0, 5'd6, 5'd7, 1'b1, 5'd0, 1'b0);
    settle();
    n_checks++; if (hazard_stall !== 1'b1) begin $display("FAIL rst_stall_pre: got %b want 1", hazard_stall); n_fails++; end
    reset = 1'b1;
    tick(); settle();
    n_checks++; if (hazard_stall !== 1'b0) begin $display("FAIL rst_stall_post: got %b want 0", hazard_stall); n_fails++; end
    n_checks++; if (wb_we !== 1'b0) begin $display("FAIL rst_we_post: got %b want 0", wb_we); n_fails++; end
    n_checks++; if (pending_mask !== 32'h0) begin $display("FAIL rst_pend_post: got %h want 0", pending_mask); n_fails++; end
    n_checks++; if (ex_dest_o !== 5'd0 || mem_dest_o !== 5'd0 || wb_dest !== 5'd0) begin
      $display("FAIL rst_dests_post: got ex=%0d mem=%0d wb=%0d want 0", ex_dest_o, mem_dest_o, wb_dest); n_fails++;
    end
    reset = 1'b0;
    drain();
  endtask

  initial begin
    reset = 1'b1;
    ex_flush = 1'b0;
    idle();
    test_reset();
    test_latency();
    test_jal_and_zero();
`ifndef SCOREBOARD_FWD_EN
    test_back_to_back();
    test_distance_two();
`else
    test_fwd();
`endif
    test_flush();
    test_reset_mid_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
